// File: rtl/fim_rdack_mc_fifo.sv
// Multi-channel read-ack FIFO: NUM_CH independent queues behind one shared write port,
// each with a prefetching output register held until rdack, per-channel flush and sticky overflow.
module fim_rdack_mc_fifo #(
    parameter int DATA_WIDTH            = 32,
    parameter int NUM_CH                = 4,
    parameter int DEPTH_LOG2            = 4,
    parameter int ALMOST_FULL_THRESHOLD = 2 ** (DEPTH_LOG2 - 1),
    localparam int WCH_W                = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W                = DEPTH_LOG2 + 1
) (
    input  logic                         clk,
    input  logic                         sclr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [WCH_W-1:0]             wch,
    input  logic                         wreq,
    input  logic [NUM_CH-1:0]            flush,
    input  logic [NUM_CH-1:0]            rdack,
    output logic [NUM_CH*DATA_WIDTH-1:0] rdata,
    output logic [NUM_CH-1:0]            rvalid,
    output logic [NUM_CH*CNT_W-1:0]      usedw,
    output logic [NUM_CH-1:0]            wfull,
    output logic [NUM_CH-1:0]            almfull,
    output logic [NUM_CH-1:0]            rempty,
    output logic [NUM_CH-1:0]            overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [WCH_W-1:0] CH_ID = WCH_W'(c);

        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DEPTH_LOG2-1:0] wptr;
        logic [DEPTH_LOG2-1:0] rptr;
        logic [CNT_W-1:0]      cnt;
        logic [DATA_WIDTH-1:0] dout;
        logic                  rv;
        logic                  ovf;
        logic                  full;
        logic                  empty;
        logic                  sel;
        logic                  push;
        logic                  pop;

        assign full  = (cnt == CNT_W'(DEPTH));
        assign empty = (cnt == '0);
        assign sel   = wreq & (wch == CH_ID);
        assign push  = sel & ~full & ~flush[c] & ~sclr;
        assign pop   = (~rv | rdack[c]) & ~empty;

        // Storage carries no reset so it can map onto LUT RAM.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wptr] <= wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (sclr) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                rv   <= 1'b0;
                ovf  <= 1'b0;
                dout <= '0;
            end else if (flush[c]) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                rv   <= 1'b0;
                ovf  <= 1'b0;
            end else begin
                if (push) begin
                    wptr <= wptr + DEPTH_LOG2'(1);
                end
                if (pop) begin
                    rptr <= rptr + DEPTH_LOG2'(1);
                    dout <= mem[rptr];
                    rv   <= 1'b1;
                end else if (rdack[c]) begin
                    rv <= 1'b0;
                end
                if (sel & full) begin
                    ovf <= 1'b1;
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
        end

        assign rdata[c*DATA_WIDTH +: DATA_WIDTH] = dout;
        assign usedw[c*CNT_W +: CNT_W]           = cnt;
        assign rvalid[c]                         = rv;
        assign wfull[c]                          = full;
        assign almfull[c]                        = (cnt >= CNT_W'(ALMOST_FULL_THRESHOLD));
        assign rempty[c]                         = empty;
        assign overflow[c]                       = ovf;
    end

endmodule
